// File: rtl/hack_alu.sv
// Hack-style W-bit two's-complement ALU with registered result and zero/negative flags.
// Latency: 1 cycle from operands/controls to out, zr, ng.
// Backpressure: none; a new operation is accepted on every clock edge.
module hack_alu #(
  parameter int W = 16  // datapath width, must be at least 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         zx,
  input  logic         nx,
  input  logic         zy,
  input  logic         ny,
  input  logic         f,
  input  logic         no,
  output logic [W-1:0] out,
  output logic         zr,
  output logic         ng
);

  // Control word grouped so the datapath reads in the same order as the opcode.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctrl_t;

  // Registered result and flags, kept together so they always describe the same op.
  typedef struct packed {
    logic [W-1:0] res;
    logic         zr;
    logic         ng;
  } result_t;

  ctrl_t        ctrl;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] sum;
  logic [W-1:0] conj;
  logic [W-1:0] r;
  result_t      nxt;
  result_t      cur;

  assign ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

  // Operand conditioning: zeroing is applied before inversion on each side.
  always_comb begin
    x1 = ctrl.zx ? '0 : x;
    x2 = ctrl.nx ? ~x1 : x1;
    y1 = ctrl.zy ? '0 : y;
    y2 = ctrl.ny ? ~y1 : y1;
  end

  // Function unit: W-bit add (carry-out dropped, wraps silently) or bitwise AND.
  always_comb begin
    sum  = x2 + y2;
    conj = x2 & y2;
    r    = ctrl.f ? sum : conj;
  end

  // Output inversion, then flags derived from the final result rather than the inputs.
  always_comb begin
    nxt     = '0;
    nxt.res = ctrl.no ? ~r : r;
    nxt.zr  = (nxt.res == '0);
    nxt.ng  = nxt.res[W-1];
  end

  // Result register; reset wins over the load so an in-flight op is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur.res <= '0;
      cur.zr  <= 1'b1;
      cur.ng  <= 1'b0;
    end else begin
      cur <= nxt;
    end
  end

  assign out = cur.res;
  assign zr  = cur.zr;
  assign ng  = cur.ng;

endmodule

// File: tb/tb_hack_alu.sv
// Directed and exhaustive-opcode bench for hack_alu at W=16, plus a W=8 smoke instance.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none; inputs are driven every cycle.
module tb_hack_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x;
  logic [15:0] y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] out;
  logic        zr, ng;
  logic [7:0]  x8;
  logic [7:0]  y8;
  logic [7:0]  out8;
  logic        zr8, ng8;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_res;
  logic [15:0] rx, ry;
  logic [15:0] prev;

  always #5 clk = ~clk;

  hack_alu #(.W(16)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out(out), .zr(zr), .ng(ng)
  );

  hack_alu #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out(out8), .zr(zr8), .ng(ng8)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [5:0] c);
    {zx, nx, zy, ny, f, no} = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string tag, input logic [15:0] eo, input logic ezr, input logic eng);
    check({tag, ".out"}, out, eo);
    check({tag, ".zr"}, {15'd0, zr}, {15'd0, ezr});
    check({tag, ".ng"}, {15'd0, ng}, {15'd0, eng});
  endtask

  task automatic apply(input string tag, input logic [15:0] ax, input logic [15:0] ay,
                       input logic [5:0] c, input logic [15:0] eo, input logic ezr, input logic eng);
    x = ax;
    y = ay;
    set_op(c);
    tick();
    check3(tag, eo, ezr, eng);
  endtask

  // Reference straight from the datapath equations, used only for the all-opcode sweep.
  function automatic logic [15:0] ref_alu(input logic [15:0] ax, input logic [15:0] ay,
                                          input logic [5:0] c);
    logic [15:0] a, b, r;
    a = c[5] ? 16'h0000 : ax;
    a = c[4] ? ~a : a;
    b = c[3] ? 16'h0000 : ay;
    b = c[2] ? ~b : b;
    r = c[1] ? 16'(a + b) : (a & b);
    return c[0] ? ~r : r;
  endfunction

  localparam logic [5:0] OP_ZERO = 6'b101010;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_XMY  = 6'b010011;
  localparam logic [5:0] OP_YMX  = 6'b000111;
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b010101;
  localparam logic [5:0] OP_NOTX = 6'b001101;
  localparam logic [5:0] OP_NOTY = 6'b110001;

  logic [5:0]  b2b_op  [8];
  logic [15:0] b2b_x   [8];
  logic [15:0] b2b_y   [8];
  logic [15:0] b2b_exp [8];

  initial begin
    // Reset held for two cycles with random inputs.
    rst = 1'b1;
    x8  = 8'h00;
    y8  = 8'h00;
    for (int i = 0; i < 2; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      set_op(6'($urandom));
      tick();
      check3($sformatf("reset%0d", i), 16'h0000, 1'b1, 1'b0);
    end
    check("reset.out8", {8'h00, out8}, 16'h0000);
    check("reset.zr8", {15'd0, zr8}, 16'h0001);

    // Release reset with 1 + 2.
    rst = 1'b0;
    apply("release_add", 16'd1, 16'd2, OP_ADD, 16'd3, 1'b0, 1'b0);

    // Subtraction and sign flag.
    apply("x_minus_y",  16'd100, 16'd50, OP_XMY, 16'd50,   1'b0, 1'b0);
    apply("y_minus_x",  16'd100, 16'd50, OP_YMX, 16'hFFCE, 1'b0, 1'b1);
    apply("zero_minus1", 16'd0,  16'd1,  OP_XMY, 16'hFFFF, 1'b0, 1'b1);
    apply("neg255",     16'd255, 16'd0,  OP_YMX, 16'hFF01, 1'b0, 1'b1);

    // Logic and zero flag.
    apply("and_disjoint", 16'h00AA, 16'h0055, OP_AND,  16'h0000, 1'b1, 1'b0);
    apply("or_disjoint",  16'h00AA, 16'h0055, OP_OR,   16'h00FF, 1'b0, 1'b0);
    apply("const_zero",   16'd100,  16'd50,   OP_ZERO, 16'h0000, 1'b1, 1'b0);

    // Inversion.
    apply("not_x", 16'd255, 16'd0,    OP_NOTX, 16'hFF00, 1'b0, 1'b1);
    apply("not_y", 16'd0,   16'h1234, OP_NOTY, 16'hEDCB, 1'b0, 1'b1);

    // Wrap and boundaries.
    apply("wrap_max",  16'h7FFF, 16'd1, OP_ADD, 16'h8000, 1'b0, 1'b1);
    apply("wrap_zero", 16'hFFFF, 16'd1, OP_ADD, 16'h0000, 1'b1, 1'b0);

    // Back-to-back: new opcode every cycle, result visible exactly one edge later.
    b2b_op  = '{OP_ADD,  OP_XMY,  OP_YMX,  OP_AND,  OP_OR,   OP_NOTX, OP_NOTY, OP_ZERO};
    b2b_x   = '{16'd7,   16'd7,   16'd7,   16'h0F0F, 16'h0F0F, 16'h0F0F, 16'd3,   16'd9};
    b2b_y   = '{16'd5,   16'd9,   16'd5,   16'h00FF, 16'h00F0, 16'd0,    16'h00FF, 16'd9};
    b2b_exp = '{16'd12,  16'hFFFE, 16'hFFFE, 16'h000F, 16'h0FFF, 16'hF0F0, 16'hFF00, 16'h0000};
    prev = out;
    for (int i = 0; i < 8; i++) begin
      x = b2b_x[i];
      y = b2b_y[i];
      set_op(b2b_op[i]);
      #1;
      check($sformatf("b2b%0d.hold", i), out, prev);
      tick();
      check($sformatf("b2b%0d.out", i), out, b2b_exp[i]);
      prev = b2b_exp[i];
    end

    // Reset during a valid ADD drops that result; next cycle loads normally.
    x = 16'd5;
    y = 16'd6;
    set_op(OP_ADD);
    rst = 1'b1;
    tick();
    check3("rst_mid", 16'h0000, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    check3("rst_after", 16'd11, 1'b0, 1'b0);

    // All 64 control codes with random operands against the equation model.
    for (int c = 0; c < 64; c++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      exp_res = ref_alu(rx, ry, 6'(c));
      apply($sformatf("code%02h", c), rx, ry, 6'(c), exp_res, (exp_res == 16'h0000), exp_res[15]);
    end

    // W=8 instance smoke test.
    x8 = 8'h7F;
    y8 = 8'h01;
    set_op(OP_ADD);
    tick();
    check("w8_wrap.out", {8'h00, out8}, 16'h0080);
    check("w8_wrap.ng", {15'd0, ng8}, 16'h0001);
    x8 = 8'hFF;
    tick();
    check("w8_zero.out", {8'h00, out8}, 16'h0000);
    check("w8_zero.zr", {15'd0, zr8}, 16'h0001);
    x8 = 8'd100;
    y8 = 8'd50;
    set_op(OP_YMX);
    tick();
    check("w8_sub.out", {8'h00, out8}, 16'h00CE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
